cache_tag_ctrl: RTL and testbench

Tag/valid controller for a set-associative cache; sits directly upstream of `cache_lru`. Accepts one lookup at a time, compares the line tag against every way of the indexed set, and reports hit/miss. On a miss it picks a fill way (an invalid way first, otherwise the LRU victim), issues a line fill request to memory, installs the new tag, and reports completion. Every hit or fill drives `update_req`/`update_set`/`update_way` into `cache_lru`.

---
 rtl/cache_tag_ctrl.sv | 148 ++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - tag/valid controller for a set-associative cache, fronting cache_lru
// Optional hit/miss counters: define CACHE_TAG_CTRL_STATS_EN.
module cache_tag_ctrl #(
  parameter int NUM_SET      = 2,
  parameter int WAYS_PER_SET = 2,
  parameter int ADDR_W       = 32,
  parameter int LINE_BYTES   = 16,
  localparam int SET_W = $clog2(NUM_SET),
  localparam int WAY_W = $clog2(WAYS_PER_SET),
  localparam int OFF_W = $clog2(LINE_BYTES),
  localparam int TAG_W = ADDR_W - SET_W - OFF_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush_req,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [WAY_W-1:0]  rsp_way,
  output logic              victim_req,
  output logic [SET_W-1:0]  victim_set,
  input  logic [WAY_W-1:0]  victim_way,
  output logic              update_req,
  output logic [SET_W-1:0]  update_set,
  output logic [WAY_W-1:0]  update_way,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid
`ifdef CACHE_TAG_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int NUM_LINES = NUM_SET * WAYS_PER_SET;
  localparam int LINE_A_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_t;

  state_t               state;
  logic [TAG_W-1:0]     tag_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [LINE_A_W-1:0]  line_q;
  logic [WAY_W-1:0]     fill_way;

  logic [SET_W-1:0] cur_set;
  logic [TAG_W-1:0] cur_tag;
  logic             unused_offset;
  assign cur_set       = line_q[SET_W-1:0];
  assign cur_tag       = line_q[LINE_A_W-1 -: TAG_W];
  assign unused_offset = ^req_addr[OFF_W-1:0];

  // Scan downward so the lowest matching / lowest invalid way wins.
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             has_inv;
  logic [WAY_W-1:0] inv_way;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS_PER_SET - 1; w >= 0; w--) begin
      if (valid[{cur_set, WAY_W'(w)}] && tag_mem[{cur_set, WAY_W'(w)}] == cur_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[{cur_set, WAY_W'(w)}]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  logic lk_hit, lk_miss, fill_done;
  assign lk_hit    = (state == LOOKUP) && hit;
  assign lk_miss   = (state == LOOKUP) && !hit;
  assign fill_done = (state == MISS_WAIT) && mem_rsp_valid;

  assign req_ready     = (state == IDLE) && !flush_req;
  assign rsp_valid     = lk_hit || fill_done;
  assign rsp_hit       = lk_hit;
  assign rsp_way       = lk_hit ? hit_way : (fill_done ? fill_way : '0);
  assign update_req    = rsp_valid;
  assign update_set    = rsp_valid ? cur_set : '0;
  assign update_way    = rsp_way;
  assign victim_req    = lk_miss && !has_inv;
  assign victim_set    = victim_req ? cur_set : '0;
  assign mem_req_valid = (state == MISS_REQ);
  assign mem_req_addr  = mem_req_valid ? {line_q, {OFF_W{1'b0}}} : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      line_q   <= '0;
      fill_way <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            valid <= '0;
          end else if (req_valid) begin
            line_q <= req_addr[ADDR_W-1:OFF_W];
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            fill_way <= has_inv ? inv_way : victim_way;
            state    <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) state <= MISS_WAIT;
        end
        MISS_WAIT: begin
          // The old line stays valid until the new data has landed.
          if (mem_rsp_valid) begin
            tag_mem[{cur_set, fill_way}] <= cur_tag;
            valid[{cur_set, fill_way}]   <= 1'b1;
            state                        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_TAG_CTRL_STATS_EN
  always_ff @(posedge clock) begin
    if (reset || (state == IDLE && flush_req)) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (lk_hit && stat_hits != '1)    stat_hits   <= stat_hits + 32'd1;
      if (lk_miss && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb/tb_cache_tag_ctrl.sv - randomized self-checking bench for cache_tag_ctrl
module tb_cache_tag_ctrl;

  localparam int NS    = 2;
  localparam int WY    = 2;
  localparam int TAG_W = 27;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        flush_req;
  logic        rsp_valid, rsp_hit;
  logic [0:0]  rsp_way;
  logic        victim_req;
  logic [0:0]  victim_set, victim_way;
  logic        update_req;
  logic [0:0]  update_set, update_way;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;

  cache_tag_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush_req(flush_req),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .victim_req(victim_req), .victim_set(victim_set), .victim_way(victim_way),
    .update_req(update_req), .update_set(update_set), .update_way(update_way),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid)
  );

  always #5 clock = ~clock;

  // Reference cache contents
  logic [TAG_W-1:0] m_tag   [NS][WY];
  bit               m_valid [NS][WY];

  // Expected outputs for the current cycle
  logic        e_req_ready, e_rsp_valid, e_rsp_hit, e_victim_req, e_update_req, e_mem_req_valid;
  logic [0:0]  e_rsp_way, e_victim_set, e_update_set, e_update_way;
  logic [31:0] e_mem_req_addr;

  int  n_assert = 0;
  int  n_fail   = 0;
  bit  check_en = 0;

  // Observations used by the literal checks
  int          victim_cnt = 0;
  int          mem_hs_cnt = 0;
  logic [31:0] last_mem_addr = '0;
  logic        last_rsp_hit = 1'b0;
  logic [0:0]  last_rsp_way = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
    n_assert++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, ex);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("req_ready", 64'(req_ready), 64'(e_req_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
      chk("rsp_hit", 64'(rsp_hit), 64'(e_rsp_hit));
      chk("rsp_way", 64'(rsp_way), 64'(e_rsp_way));
      chk("victim_req", 64'(victim_req), 64'(e_victim_req));
      chk("victim_set", 64'(victim_set), 64'(e_victim_set));
      chk("update_req", 64'(update_req), 64'(e_update_req));
      chk("update_set", 64'(update_set), 64'(e_update_set));
      chk("update_way", 64'(update_way), 64'(e_update_way));
      chk("mem_req_valid", 64'(mem_req_valid), 64'(e_mem_req_valid));
      chk("mem_req_addr", 64'(mem_req_addr), 64'(e_mem_req_addr));
      if (victim_req) victim_cnt++;
      if (mem_req_valid && mem_req_ready) mem_hs_cnt++;
      if (mem_req_valid) last_mem_addr = mem_req_addr;
      if (rsp_valid) begin
        last_rsp_hit = rsp_hit;
        last_rsp_way = rsp_way;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_exp();
    e_req_ready = 0; e_rsp_valid = 0; e_rsp_hit = 0; e_rsp_way = 0;
    e_victim_req = 0; e_victim_set = 0; e_update_req = 0; e_update_set = 0;
    e_update_way = 0; e_mem_req_valid = 0; e_mem_req_addr = 0;
  endtask

  task automatic model_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < WY; w++) m_valid[s][w] = 0;
  endtask

  // Inputs that must be ignored while busy get random values.
  task automatic busy_noise();
    clear_exp();
    req_valid     = 1'($urandom);
    req_addr      = $urandom;
    flush_req     = 1'($urandom);
    mem_rsp_valid = 1'($urandom);
    mem_req_ready = 1'($urandom);
  endtask

  task automatic idle(input bit fl, input bit rv);
    clear_exp();
    flush_req     = fl;
    req_valid     = fl ? rv : 1'b0;
    req_addr      = $urandom;
    mem_rsp_valid = 1'($urandom);
    mem_req_ready = 1'($urandom);
    e_req_ready   = !fl;
    tick();
    if (fl) model_clear();
  endtask

  task automatic lookup(input logic [31:0] a, input logic [0:0] vw, input int rdly,
                        input int wdly, input bit rst_wait);
    int s, hw, inv, fill;
    bit hit;
    logic [TAG_W-1:0] t;
    s = int'(a[4]);
    t = a[31:5];
    // accept
    clear_exp();
    req_valid = 1; req_addr = a; flush_req = 0;
    mem_rsp_valid = 1'($urandom); mem_req_ready = 1'($urandom);
    e_req_ready = 1;
    tick();
    // lookup
    hit = 0; hw = 0; inv = -1;
    for (int w = WY - 1; w >= 0; w--) begin
      if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1; hw = w; end
      if (!m_valid[s][w]) inv = w;
    end
    busy_noise();
    victim_way = vw;
    if (hit) begin
      e_rsp_valid = 1; e_rsp_hit = 1; e_rsp_way = 1'(hw);
      e_update_req = 1; e_update_set = 1'(s); e_update_way = 1'(hw);
      tick();
      return;
    end
    e_victim_req = (inv < 0);
    e_victim_set = (inv < 0) ? 1'(s) : 1'b0;
    fill = (inv < 0) ? int'(vw) : inv;
    tick();
    for (int i = 0; i <= rdly; i++) begin
      busy_noise();
      mem_req_ready   = (i == rdly);
      e_mem_req_valid = 1;
      e_mem_req_addr  = {a[31:4], 4'h0};
      tick();
    end
    for (int i = 0; i <= wdly; i++) begin
      busy_noise();
      mem_rsp_valid = 0;
      if (i == wdly) begin
        if (rst_wait) begin
          reset = 1;
          tick();
          reset = 0;
          model_clear();
          return;
        end
        mem_rsp_valid = 1;
        e_rsp_valid = 1; e_rsp_hit = 0; e_rsp_way = 1'(fill);
        e_update_req = 1; e_update_set = 1'(s); e_update_way = 1'(fill);
      end
      tick();
    end
    m_tag[s][fill]   = t;
    m_valid[s][fill] = 1;
  endtask

  initial begin
    int vc, hc;
    logic [31:0] a;
    reset = 1; req_valid = 0; req_addr = 0; flush_req = 0;
    victim_way = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    clear_exp();
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    check_en = 1;
    idle(0, 0);
    idle(0, 0);

    // first fill of 0x10 goes to invalid way 0
    vc = victim_cnt;
    lookup(32'h10, 1'b1, 0, 1, 0);
    chk("lit_first_victim", 64'(victim_cnt - vc), 64'd0);
    chk("lit_first_memaddr", 64'(last_mem_addr), 64'h10);
    chk("lit_first_hit", 64'(last_rsp_hit), 64'd0);
    chk("lit_first_way", 64'(last_rsp_way), 64'd0);

    hc = mem_hs_cnt;
    lookup(32'h10, 1'b0, 0, 0, 0);
    chk("lit_rehit_hit", 64'(last_rsp_hit), 64'd1);
    chk("lit_rehit_way", 64'(last_rsp_way), 64'd0);
    chk("lit_rehit_nomem", 64'(mem_hs_cnt - hc), 64'd0);

    hc = mem_hs_cnt;
    lookup(32'h30, 1'b0, 5, 2, 0);
    chk("lit_stall_one_req", 64'(mem_hs_cnt - hc), 64'd1);
    chk("lit_30_way", 64'(last_rsp_way), 64'd1);

    vc = victim_cnt;
    lookup(32'h50, 1'b1, 1, 0, 0);
    chk("lit_victim_once", 64'(victim_cnt - vc), 64'd1);
    chk("lit_victim_fill", 64'(last_rsp_way), 64'd1);
    lookup(32'h30, 1'b1, 0, 0, 0);
    chk("lit_30_evicted", 64'(last_rsp_hit), 64'd0);
    lookup(32'h1C, 1'b0, 0, 0, 0);
    chk("lit_10_survives", 64'(last_rsp_hit), 64'd1);

    idle(1, 1);
    lookup(32'h10, 1'b0, 0, 0, 0);
    chk("lit_flush_miss", 64'(last_rsp_hit), 64'd0);

    lookup(32'h30, 1'b0, 0, 2, 1);
    idle(0, 0);
    lookup(32'h10, 1'b0, 0, 0, 0);
    chk("lit_reset_miss", 64'(last_rsp_hit), 64'd0);

    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 3) << 5) | (($urandom % 2) << 4) | ($urandom % 16);
      if ($urandom % 16 == 0) idle(1, 1'($urandom));
      if ($urandom % 4 == 0) idle(0, 0);
      lookup(a, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), ($urandom % 40) == 0);
    end
    idle(0, 0);
    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
